// File: rtl/fifo_rd_downsizer_pkg.sv
// rtl/fifo_rd_downsizer_pkg.sv - shared state encoding and slice-geometry helpers for the read downsizer
package fifo_rd_downsizer_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic int ratio_of(input int data_len, input int out_len);
        return data_len / out_len;
    endfunction

    // A single-slice word still needs a one-bit index so the registers stay legal
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_slice_mux.sv
// rtl/fifo_rd_slice_mux.sv - combinational index-to-slice select, slice 0 is the low bits
module fifo_rd_slice_mux
    import fifo_rd_downsizer_pkg::*;
#(
    parameter int DATA_LEN = 64,
    parameter int OUT_LEN  = 32
) (
    input  logic [DATA_LEN-1:0]                                  data,
    input  logic [idx_width(ratio_of(DATA_LEN, OUT_LEN))-1:0]    idx,
    output logic [OUT_LEN-1:0]                                   slice
);

    localparam int RATIO = ratio_of(DATA_LEN, OUT_LEN);
    localparam int IDX_W = idx_width(RATIO);

    always_comb begin
        slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx == IDX_W'(i)) begin
                slice = data[i*OUT_LEN +: OUT_LEN];
            end
        end
    end

endmodule

// File: rtl/fifo_rd_downsizer.sv
// rtl/fifo_rd_downsizer.sv - pops wide words from a read-through FIFO and emits them as narrow beats
module fifo_rd_downsizer
    import fifo_rd_downsizer_pkg::*;
#(
    parameter int DATA_LEN = 64,
    parameter int OUT_LEN  = 32,
    parameter int CNT_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    output logic                fifo_ren,
    input  logic [DATA_LEN-1:0] fifo_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_LEN-1:0]  out_data,
    output logic                out_last,
    output logic [CNT_LEN-1:0]  word_cnt
);

    localparam int RATIO = ratio_of(DATA_LEN, OUT_LEN);
    localparam int IDX_W = idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_LEN-1:0]   data_buf;
    logic [CNT_LEN-1:0]    cnt_q;

    logic hold;
    logic slice_last;
    logic beat_done;

    assign hold       = (state == ST_HOLD);
    assign slice_last = (idx == LAST_IDX);
    assign beat_done  = hold & out_ready;

    // Popping on the final beat's handshake refills the buffer with no bubble; reset
    // gates the strobe so a reset never advances the FIFO read pointer.
    assign fifo_ren  = rst_n & ~fifo_empty & ~flush & (~hold | (beat_done & slice_last));
    assign out_valid = hold;
    assign out_last  = hold & slice_last;
    assign word_cnt  = cnt_q;

    fifo_rd_slice_mux #(
        .DATA_LEN (DATA_LEN),
        .OUT_LEN  (OUT_LEN)
    ) u_slice_mux (
        .data  (data_buf),
        .idx   (idx),
        .slice (out_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            idx      <= '0;
            data_buf <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
            idx   <= '0;
        end else if (fifo_ren) begin
            state    <= ST_HOLD;
            idx      <= '0;
            data_buf <= fifo_data;
            cnt_q    <= cnt_q + CNT_LEN'(1);
        end else if (beat_done) begin
            if (slice_last) begin
                state <= ST_EMPTY;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// tb/tb_fifo_rd_downsizer.sv - randomized and directed checks of the downsizer against a queue-based beat model
module tb_fifo_rd_downsizer;

    localparam int DL = 64;
    localparam int OL = 32;
    localparam int RT = DL / OL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_ren;
    logic [DL-1:0] fifo_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OL-1:0] out_data;
    logic          out_last;
    logic [15:0]   word_cnt;

    logic          p_rst_n = 1'b0;
    logic          p_empty = 1'b1;
    logic          p_ren;
    logic [DL-1:0] p_data = '0;
    logic          p_valid;
    logic [DL-1:0] p_out;
    logic          p_last;
    logic [15:0]   p_cnt;

    always #5 clk = ~clk;

    fifo_rd_downsizer #(.DATA_LEN(DL), .OUT_LEN(OL), .CNT_LEN(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
        .fifo_data(fifo_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .word_cnt(word_cnt)
    );

    fifo_rd_downsizer #(.DATA_LEN(DL), .OUT_LEN(DL), .CNT_LEN(16)) u_pass (
        .clk(clk), .rst_n(p_rst_n), .fifo_empty(p_empty), .fifo_ren(p_ren),
        .fifo_data(p_data), .flush(1'b0), .out_valid(p_valid), .out_ready(1'b1),
        .out_data(p_out), .out_last(p_last), .word_cnt(p_cnt)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ren_cnt = 0;
    bit model_on = 0;

    logic [DL-1:0] fq[$];
    logic [OL-1:0] pend[$];
    logic [15:0]   m_cnt = '0;
    logic [OL-1:0] log_d[$];
    bit            log_l[$];
    int            log_c[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? {$urandom, $urandom} : fq[0];
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_l.delete();
        log_c.delete();
        ren_cnt = 0;
    endtask

    // One clock: compare at negedge, then advance the beat-queue model across the edge.
    task automatic cycle();
        bit e_valid, e_ren, s_rst, s_flush, s_hs, s_dut_ren;
        logic [DL-1:0] s_head;
        @(negedge clk);
        e_valid = (pend.size() > 0);
        e_ren = rst_n && !fifo_empty && !flush && (!e_valid || (out_ready && pend.size() == 1));
        if (model_on) begin
            chk("out_valid", out_valid, e_valid);
            chk("fifo_ren", fifo_ren, e_ren);
            chk("word_cnt", word_cnt, m_cnt);
            if (e_valid) begin
                chk("out_data", out_data, pend[0]);
                chk("out_last", out_last, pend.size() == 1);
            end else begin
                chk("out_last_idle", out_last, 1'b0);
            end
        end
        if (out_valid && out_ready) begin
            log_d.push_back(out_data);
            log_l.push_back(out_last);
            log_c.push_back(cyc);
        end
        if (fifo_ren) ren_cnt++;
        s_rst = rst_n; s_flush = flush; s_hs = e_valid && out_ready;
        s_dut_ren = fifo_ren; s_head = fifo_data;
        @(posedge clk);
        if (!s_rst) begin
            pend.delete();
            m_cnt = '0;
        end else if (s_flush) begin
            pend.delete();
        end else begin
            if (s_hs) void'(pend.pop_front());
            if (e_ren) begin
                for (int i = 0; i < RT; i++) pend.push_back(s_head[i*OL +: OL]);
                m_cnt = m_cnt + 16'd1;
            end
        end
        if (s_dut_ren && fq.size() > 0) void'(fq.pop_front());
        cyc++;
        #1;
        drive_fifo();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [DL-1:0] w0, w1;
        int qs;

        // Reset state and single-word split
        drive_fifo();
        rst_n = 1'b0;
        cycle();
        model_on = 1;
        cycle();
        rst_n = 1'b1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_ren", fifo_ren, 1'b0);
        chk("rst_cnt", word_cnt, 16'h0);
        fq.push_back(64'h1111_2222_3333_4444);
        out_ready = 1'b1;
        drive_fifo();
        clear_logs();
        run(5);
        chk("w1_beats", log_d.size(), 2);
        if (log_d.size() == 2) begin
            chk("w1_b0", log_d[0], 32'h3333_4444);
            chk("w1_b0_last", log_l[0], 1'b0);
            chk("w1_b1", log_d[1], 32'h1111_2222);
            chk("w1_b1_last", log_l[1], 1'b1);
        end
        chk("w1_cnt", word_cnt, 16'd1);
        chk("w1_ren", ren_cnt, 1);

        // Back-to-back words with no bubble
        do_reset();
        for (int i = 0; i < 3; i++) fq.push_back({$urandom, $urandom});
        drive_fifo();
        clear_logs();
        run(9);
        chk("b2b_beats", log_d.size(), 6);
        if (log_c.size() == 6) chk("b2b_span", log_c[5] - log_c[0], 5);
        chk("b2b_ren", ren_cnt, 3);
        chk("b2b_cnt", word_cnt, 16'd3);

        // Backpressure mid-word
        do_reset();
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        fq.push_back(w0);
        fq.push_back(w1);
        drive_fifo();
        run(2);
        out_ready = 1'b0;
        clear_logs();
        run(5);
        chk("bp_ren", ren_cnt, 0);
        chk("bp_data", out_data, w0[63:32]);
        chk("bp_last", out_last, 1'b1);
        out_ready = 1'b1;
        run(5);
        chk("bp_beats", log_d.size(), 3);
        if (log_d.size() == 3) begin
            chk("bp_b0", log_d[0], w0[63:32]);
            chk("bp_b1", log_d[1], w1[31:0]);
            chk("bp_b2", log_d[2], w1[63:32]);
        end

        // Flush at idx=1 of word A with word B waiting
        do_reset();
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        fq.push_back(w0);
        fq.push_back(w1);
        drive_fifo();
        run(2);
        flush = 1'b1;
        clear_logs();
        cycle();
        flush = 1'b0;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_noren", ren_cnt, 0);
        clear_logs();
        run(4);
        if (log_d.size() > 0) chk("fl_b_low", log_d[0], w1[31:0]);
        else chk("fl_b_beats", log_d.size(), 2);

        // Reset mid-word leaves the FIFO untouched
        fq.delete();
        do_reset();
        fq.push_back({$urandom, $urandom});
        fq.push_back({$urandom, $urandom});
        drive_fifo();
        cycle();
        out_ready = 1'b0;
        cycle();
        qs = fq.size();
        rst_n = 1'b0;
        cycle();
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_data", out_data, 32'h0);
        chk("mr_last", out_last, 1'b0);
        chk("mr_ren", fifo_ren, 1'b0);
        chk("mr_cnt", word_cnt, 16'h0);
        chk("mr_fifo", fq.size(), qs);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (fq.size() < 4 && $urandom_range(0, 1) == 1) fq.push_back({$urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            drive_fifo();
            cycle();
        end
        rst_n = 1'b1;
        flush = 1'b0;

        // RATIO=1 pass-through and counter wrap
        p_empty = 1'b0;
        @(posedge clk);
        #1;
        p_rst_n = 1'b1;
        for (int k = 0; k < 65536; k++) begin
            p_data = {32'(k), ~32'(k)};
            @(negedge clk);
            chk("p_ren", p_ren, 1'b1);
            if (k > 0) begin
                chk("p_valid", p_valid, 1'b1);
                chk("p_data", p_out, {32'(k - 1), ~32'(k - 1)});
                chk("p_last", p_last, 1'b1);
            end else begin
                chk("p_first_valid", p_valid, 1'b0);
            end
            if (k == 65535) chk("p_cnt_ffff", p_cnt, 16'hFFFF);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("p_cnt_wrap", p_cnt, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
